fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the mMIPS pipeline and the consumer of the branch controller's `Branch` decision. It owns the program counter, issues word requests to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register. It also absorbs decode stalls in a one-entry skid buffer and redirects to `BranchTarget` whenever `Branch` is asserted, flushing any wrong-path instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `Branch`  in  1  redirect request from branch control; sampled every cycle.
- `BranchTarget`  in  32  redirect address, valid when `Branch`=1.
- `Stall`  in  1  hazard unit holds IF/ID and fetch progress.
- `imem_req`  out  1  instruction memory request.
- `imem_addr`  out  32  word address of request.
- `imem_ack`  in  1  memory returns `imem_rdata` for the current request this cycle.
- `imem_rdata`  in  32  instruction word.
- `IfId_Instr`  out  32  instruction to decode.
- `IfId_PC`  out  32  fetch address + 4 of `IfId_Instr`.
- `IfId_Valid`  out  1  IF/ID holds a real instruction; 0 = bubble.

## Operation
- Registers:
  - `addr_q` (drives `imem_addr`)
  - `tgt_q` (pending target)
  - skid `{instr, pc}`
  - IF/ID `{Instr, PC, Valid}`
  - state ∈ {IDLE, FETCH, HOLD, DRAIN}
- Handshake:
  - A transfer completes on an edge where `imem_req`=1 and `imem_ack`=1.
  - While `imem_req`=1 and no ack, `imem_addr` stays constant; the request is never withdrawn.
  - Any number of wait cycles ≥0 is allowed.
- `imem_req` = 1 in FETCH and DRAIN; 0 in IDLE and HOLD.
- Priority within each state: `Branch` > `Stall` > normal progress.
- IDLE → FETCH unconditionally on the first edge after reset release.
- FETCH:
  - ack & Branch: discard data, IF/ID Valid←0, `addr_q`←BranchTarget, stay.
  - !ack & Branch: IF/ID Valid←0, `tgt_q`←BranchTarget, → DRAIN.
  - ack & !Stall: IF/ID←{rdata, addr_q+4, 1}, `addr_q`←addr_q+4, stay.
  - ack & Stall: skid←{rdata, addr_q+4}, `addr_q`←addr_q+4, IF/ID held, → HOLD.
  - !ack & !Stall: IF/ID Valid←0 (bubble); Instr/PC hold.
  - !ack & Stall: IF/ID held.
- HOLD:
  - Branch: discard skid, IF/ID Valid←0, `addr_q`←BranchTarget, → FETCH.
  - !Stall: IF/ID←{skid, 1}, → FETCH.
  - otherwise stay.
- DRAIN (wrong-path request still in flight):
  - IF/ID Valid←0 every cycle.
  - Branch updates `tgt_q`; the latest target wins, and Branch together with ack uses the new BranchTarget.
  - On ack: discard rdata, `addr_q`←tgt_q, → FETCH.
  - `Stall` is ignored.
- Address arithmetic:
  - 32-bit, modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  - Low two address bits pass through unchanged; alignment is not checked.

## Timing
- Reset values:
  - state=IDLE
  - `imem_req`=0
  - `imem_addr`=RESET_PC
  - `IfId_Instr`=0
  - `IfId_PC`=0
  - `IfId_Valid`=0
  - skid=0, `tgt_q`=0
- First request: `imem_req` rises one cycle after reset release, at RESET_PC.
- Zero-wait memory (ack in the request cycle): one instruction per cycle. The instruction fetched at edge N is in IF/ID after edge N.
- Wait states: each non-ack cycle inserts one bubble (IfId_Valid=0).
- Branch penalty, zero-wait memory: the target instruction appears in IF/ID one edge after the redirect edge plus one fetch. That is exactly one bubble cycle.
- Branch penalty with a request in flight: penalty = remaining wait cycles + 1.
- Stall release from HOLD: the skid entry reaches IF/ID on the release edge, and the next fetch is issued in the following cycle.
- Reset asserted mid-transfer: all state clears immediately (asynchronous) and `imem_req` drops. The memory is required to abandon the request.

## Test plan
- Reset, RESET_PC=0x0000_0400, zero-wait memory returning addr as data → `imem_req` rises 1 cycle after reset release. IF/ID then shows (0x400, PC 0x404), (0x404, 0x408), … with Valid=1 every cycle.
- 2-wait-state memory → each instruction preceded by 2 Valid=0 cycles; `imem_addr` constant during waits.
- Branch=1, BranchTarget=0x100 while fetching 0x20, zero-wait → 0x20 data discarded and Valid=0 for one cycle. The next valid instruction is from 0x100 with IfId_PC=0x104.
- Branch during the first of 3 wait cycles at 0x40, then a second Branch to 0x200 before ack → `imem_addr` stays 0x40 until ack and no 0x40 data reaches IF/ID. The next fetch is 0x200.
- Stall held 3 cycles as ack arrives for 0x10 → `imem_req`=0 in HOLD and IF/ID is unchanged. On release, IF/ID=(instr@0x10, 0x14), Valid=1, and 0x14 is requested the next cycle.
- Address 0xFFFF_FFFC fetched → next `imem_addr`=0x0000_0000 and IfId_PC=0x0000_0000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// mMIPS instruction fetch: program counter, imem req/ack master, one-entry skid buffer,
// branch redirect with wrong-path flush, and the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Branch,
    input  logic [31:0]  BranchTarget,
    input  logic         Stall,
    fetch_unit_if.master imem,
    output logic [31:0]  IfId_Instr,
    output logic [31:0]  IfId_PC,
    output logic         IfId_Valid
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDrain
    } state_e;

    state_e      state_q;
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] tgt_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] addr_inc;

    // Wraps modulo 2^32; low bits are carried through untouched.
    assign addr_inc = addr_q + 32'd4;

    assign imem.req   = req_q;
    assign imem.addr  = addr_q;
    assign IfId_Instr = instr_q;
    assign IfId_PC    = pc_q;
    assign IfId_Valid = valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            tgt_q        <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            instr_q      <= 32'h0;
            pc_q         <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                    req_q   <= 1'b1;
                end
                StFetch: begin
                    if (Branch) begin
                        valid_q <= 1'b0;
                        if (imem.ack) begin
                            addr_q <= BranchTarget;
                        end else begin
                            // Request cannot be withdrawn; let it finish and drop its data.
                            tgt_q   <= BranchTarget;
                            state_q <= StDrain;
                        end
                    end else if (imem.ack) begin
                        addr_q <= addr_inc;
                        if (Stall) begin
                            skid_instr_q <= imem.rdata;
                            skid_pc_q    <= addr_inc;
                            state_q      <= StHold;
                            req_q        <= 1'b0;
                        end else begin
                            instr_q <= imem.rdata;
                            pc_q    <= addr_inc;
                            valid_q <= 1'b1;
                        end
                    end else if (!Stall) begin
                        valid_q <= 1'b0;
                    end
                end
                StHold: begin
                    if (Branch) begin
                        valid_q <= 1'b0;
                        addr_q  <= BranchTarget;
                        state_q <= StFetch;
                        req_q   <= 1'b1;
                    end else if (!Stall) begin
                        instr_q <= skid_instr_q;
                        pc_q    <= skid_pc_q;
                        valid_q <= 1'b1;
                        state_q <= StFetch;
                        req_q   <= 1'b1;
                    end
                end
                StDrain: begin
                    valid_q <= 1'b0;
                    if (imem.ack) begin
                        addr_q  <= Branch ? BranchTarget : tgt_q;
                        state_q <= StFetch;
                    end else if (Branch) begin
                        tgt_q <= BranchTarget;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then randomized
// memory latency, branches and stalls checked every cycle against a queue-based model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Branch = 1'b0;
    logic        Stall = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic [31:0] IfId_Instr;
    logic [31:0] IfId_PC;
    logic        IfId_Valid;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .Branch       (Branch),
        .BranchTarget (BranchTarget),
        .Stall        (Stall),
        .imem         (bus.master),
        .IfId_Instr   (IfId_Instr),
        .IfId_PC      (IfId_PC),
        .IfId_Valid   (IfId_Valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory behaviour
    bit          mem_random = 1'b0;
    int          mem_wait_max = 0;
    bit          mem_busy = 1'b0;
    int          mem_left = 0;
    logic [31:0] mem_key = 32'h0;

    // Reference model: fetch pointer, wrong-path flag, skid queue, IF/ID contents
    bit          m_started;
    bit          m_dead;
    logic [63:0] m_skid[$];
    logic [31:0] m_addr;
    logic [31:0] m_tgt;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    bit          m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_dead    = 1'b0;
        m_skid.delete();
        m_addr    = RST_PC;
        m_tgt     = 32'h0;
        m_instr   = 32'h0;
        m_pc      = 32'h0;
        m_valid   = 1'b0;
        mem_busy  = 1'b0;
    endtask

    function automatic bit m_req();
        return m_started && (m_skid.size() == 0);
    endfunction

    task automatic model_step(input bit br, input logic [31:0] bt, input bit st, input bit ack);
        if (!m_started) begin
            m_started = 1'b1;
        end else if (m_skid.size() != 0) begin
            if (br) begin
                m_skid.delete();
                m_valid = 1'b0;
                m_addr  = bt;
            end else if (!st) begin
                {m_instr, m_pc} = m_skid.pop_front();
                m_valid = 1'b1;
            end
        end else if (m_dead) begin
            m_valid = 1'b0;
            if (br) m_tgt = bt;
            if (ack) begin
                m_addr = m_tgt;
                m_dead = 1'b0;
            end
        end else if (br) begin
            m_valid = 1'b0;
            if (ack) m_addr = bt;
            else begin
                m_tgt  = bt;
                m_dead = 1'b1;
            end
        end else if (ack) begin
            if (st) m_skid.push_back({m_addr ^ mem_key, m_addr + 32'd4});
            else begin
                m_instr = m_addr ^ mem_key;
                m_pc    = m_addr + 32'd4;
                m_valid = 1'b1;
            end
            m_addr = m_addr + 32'd4;
        end else if (!st) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_model();
        chk("req", {31'b0, bus.req}, {31'b0, m_req()});
        chk("addr", bus.addr, m_addr);
        chk("valid", {31'b0, IfId_Valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("instr", IfId_Instr, m_instr);
            chk("pc", IfId_PC, m_pc);
        end
    endtask

    // Called at a negedge: apply inputs, answer the memory request, advance the model
    // over the coming edge, then compare on the following negedge.
    task automatic cycle(input bit br, input logic [31:0] bt, input bit st);
        Branch       = br;
        BranchTarget = bt;
        Stall        = st;
        if (bus.req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_left = mem_random ? int'($urandom_range(mem_wait_max, 0)) : mem_wait_max;
            end
            if (mem_left == 0) begin
                bus.ack   = 1'b1;
                bus.rdata = bus.addr ^ mem_key;
                mem_busy  = 1'b0;
            end else begin
                bus.ack   = 1'b0;
                bus.rdata = $urandom;
                mem_left--;
            end
        end else begin
            bus.ack   = 1'b0;
            bus.rdata = $urandom;
        end
        model_step(br, bt, st, bus.ack);
        @(negedge clk);
        compare_model();
    endtask

    task automatic rand_cycle();
        logic [31:0] bt;
        bt = $urandom;
        if ($urandom_range(15, 0) == 0) bt = 32'hFFFF_FFF0 | ($urandom_range(15, 0));
        cycle($urandom_range(7, 0) == 0, bt, $urandom_range(3, 0) == 0);
    endtask

    initial begin
        bus.ack   = 1'b0;
        bus.rdata = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_req", {31'b0, bus.req}, 32'd0);
        chk("rst_addr", bus.addr, RST_PC);
        chk("rst_instr", IfId_Instr, 32'h0);
        chk("rst_pc", IfId_PC, 32'h0);
        chk("rst_valid", {31'b0, IfId_Valid}, 32'd0);
        rst = 1'b1;

        // Zero-wait stream, memory returns its address
        cycle(0, 0, 0);
        chk("first_req", {31'b0, bus.req}, 32'd1);
        chk("first_addr", bus.addr, 32'h400);
        cycle(0, 0, 0);
        chk("s0_valid", {31'b0, IfId_Valid}, 32'd1);
        chk("s0_instr", IfId_Instr, 32'h400);
        chk("s0_pc", IfId_PC, 32'h404);
        cycle(0, 0, 0);
        chk("s1_instr", IfId_Instr, 32'h404);
        chk("s1_pc", IfId_PC, 32'h408);

        // Two wait states
        mem_wait_max = 2;
        cycle(0, 0, 0);
        chk("w1_valid", {31'b0, IfId_Valid}, 32'd0);
        chk("w1_addr", bus.addr, 32'h408);
        cycle(0, 0, 0);
        chk("w2_valid", {31'b0, IfId_Valid}, 32'd0);
        chk("w2_addr", bus.addr, 32'h408);
        cycle(0, 0, 0);
        chk("w3_valid", {31'b0, IfId_Valid}, 32'd1);
        chk("w3_instr", IfId_Instr, 32'h408);
        chk("w3_pc", IfId_PC, 32'h40C);

        // Zero-wait branch while fetching 0x20
        mem_wait_max = 0;
        cycle(1, 32'h20, 0);
        chk("b0_addr", bus.addr, 32'h20);
        cycle(1, 32'h100, 0);
        chk("b1_valid", {31'b0, IfId_Valid}, 32'd0);
        chk("b1_addr", bus.addr, 32'h100);
        cycle(0, 0, 0);
        chk("b2_valid", {31'b0, IfId_Valid}, 32'd1);
        chk("b2_instr", IfId_Instr, 32'h100);
        chk("b2_pc", IfId_PC, 32'h104);

        // Branch with a request in flight, retargeted before the ack
        cycle(1, 32'h40, 0);
        mem_wait_max = 3;
        cycle(1, 32'h300, 0);
        chk("d0_addr", bus.addr, 32'h40);
        chk("d0_valid", {31'b0, IfId_Valid}, 32'd0);
        cycle(1, 32'h200, 0);
        chk("d1_addr", bus.addr, 32'h40);
        cycle(0, 0, 0);
        chk("d2_addr", bus.addr, 32'h40);
        chk("d2_req", {31'b0, bus.req}, 32'd1);
        cycle(0, 0, 0);
        chk("d3_addr", bus.addr, 32'h200);
        chk("d3_valid", {31'b0, IfId_Valid}, 32'd0);
        mem_wait_max = 0;
        cycle(0, 0, 0);
        chk("d4_instr", IfId_Instr, 32'h200);
        chk("d4_pc", IfId_PC, 32'h204);

        // Stall held three cycles as 0x10 is acknowledged
        cycle(1, 32'h0C, 0);
        cycle(0, 0, 0);
        chk("h0_instr", IfId_Instr, 32'h0C);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1);
            chk("h_req", {31'b0, bus.req}, 32'd0);
            chk("h_instr", IfId_Instr, 32'h0C);
            chk("h_pc", IfId_PC, 32'h10);
            chk("h_valid", {31'b0, IfId_Valid}, 32'd1);
        end
        cycle(0, 0, 0);
        chk("r_instr", IfId_Instr, 32'h10);
        chk("r_pc", IfId_PC, 32'h14);
        chk("r_req", {31'b0, bus.req}, 32'd1);
        chk("r_addr", bus.addr, 32'h14);
        cycle(0, 0, 0);
        chk("r1_instr", IfId_Instr, 32'h14);

        // Address wrap
        cycle(1, 32'hFFFF_FFFC, 0);
        chk("wrap_addr0", bus.addr, 32'hFFFF_FFFC);
        cycle(0, 0, 0);
        chk("wrap_instr", IfId_Instr, 32'hFFFF_FFFC);
        chk("wrap_pc", IfId_PC, 32'h0);
        chk("wrap_addr1", bus.addr, 32'h0);

        // Randomized traffic
        mem_key      = 32'hC0DE_0000;
        mem_random   = 1'b1;
        mem_wait_max = 3;
        repeat (3000) rand_cycle();

        // Asynchronous reset with a request outstanding
        mem_random   = 1'b0;
        mem_wait_max = 3;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0);
            if (m_req() && mem_busy) break;
        end
        chk("pre_rst_req", {31'b0, bus.req}, 32'd1);
        #2 rst = 1'b0;
        bus.ack = 1'b0;
        #1;
        chk("async_req", {31'b0, bus.req}, 32'd0);
        chk("async_addr", bus.addr, RST_PC);
        chk("async_valid", {31'b0, IfId_Valid}, 32'd0);
        chk("async_instr", IfId_Instr, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_random = 1'b1;
        repeat (300) rand_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
